// File: rtl/bias_trim_cfg.sv
// -----------------------------------------------------------------------------
// bias_trim_cfg
//
// Configuration front end for the bias amplifier macro. A 3-wire serial
// master (sclk/cs_n/sdi, all asynchronous to clk) writes and reads four 8-bit
// registers. Latched trim codes and enables drive the analog block, and
// register contents are shifted back out on sdo for off-chip verification.
//
// Frame: 16 bits, MSB first, sampled on sclk rising edges.
//   cmd[7] = 1 read / 0 write, cmd[6:2] ignored, cmd[1:0] = address,
//   followed by data[7:0].
// Registers: 0 BIAS_CODE (rw), 1 GAIN_CODE (rw), 2 CTRL (rw, bit0 amp_en,
//   bit1 chop_en), 3 ID (ro, DEVICE_ID; writes dropped silently).
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   sclk_i, cs_n_i,   serial clock, frame select (active low), serial data in
//   sdi_i
//   sdo_o, sdo_oe_o   readback data and its pad output enable
//   bias_code_o       bias DAC trim
//   gain_code_o       gain trim
//   amp_en_o          amplifier enable
//   chop_en_o         chopper enable
//   cfg_update_o      one-cycle pulse when a write commits
//   frame_err_o       one-cycle pulse when a malformed frame is discarded
//
// Master timing: sclk high/low phases and cs_n setup/hold to sclk must each be
// at least SYNC_STAGES+2 clk periods. SYNC_STAGES must be at least 2.
// -----------------------------------------------------------------------------
module bias_trim_cfg #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  BIAS_RST    = 8'h80,
  parameter logic [7:0]  DEVICE_ID   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_i,
  input  logic       cs_n_i,
  input  logic       sdi_i,
  output logic       sdo_o,
  output logic       sdo_oe_o,
  output logic [7:0] bias_code_o,
  output logic [7:0] gain_code_o,
  output logic       amp_en_o,
  output logic       chop_en_o,
  output logic       cfg_update_o,
  output logic       frame_err_o
);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    CMD       = 2'd2,
    DATA      = 2'd3
  } state_t;

  // After reset the synchroniser chains hold their reset values rather than
  // the real pin levels; the FSM must not trust them until every stage and
  // the edge-detect flop have been refilled from the pins.
  localparam int FLUSH = SYNC_STAGES + 1;
  localparam int FW    = $clog2(FLUSH + 1);

  state_t r_state, w_state_next;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_sdi_sync;
  logic                   r_sclk_d, r_cs_d;
  logic [FW-1:0]          r_flush_cnt;

  logic       w_sclk_s, w_cs_s, w_sdi_s;
  logic       w_sclk_rise, w_cs_rise, w_cs_fall, w_flushed;

  logic [4:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_cmd;
  logic [7:0] r_rb;
  logic [7:0] w_cmd_next;
  logic [7:0] w_rd_data;

  logic [7:0] r_bias, r_gain;
  logic       r_amp, r_chop;
  logic       r_sdo, r_sdo_oe;
  logic       r_cfg_update, r_frame_err;

  // ---------------------------------------------------------------------------
  // Input synchronisers and edge detection
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_sdi_sync  <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
      r_flush_cnt <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_i};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   cs_n_i};
      r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0],  sdi_i};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
      if (!w_flushed) begin
        r_flush_cnt <= r_flush_cnt + FW'(1);
      end
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_sdi_s     = r_sdi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_cs_rise   = w_cs_s & ~r_cs_d;
  assign w_cs_fall   = ~w_cs_s & r_cs_d;
  assign w_flushed   = (r_flush_cnt == FW'(FLUSH));

  // Command byte as it will look once the current sdi bit is shifted in.
  assign w_cmd_next = {r_shift[6:0], w_sdi_s};

  always_comb begin
    w_rd_data = DEVICE_ID;
    case (w_cmd_next[1:0])
      2'd0:    w_rd_data = r_bias;
      2'd1:    w_rd_data = r_gain;
      2'd2:    w_rd_data = {6'b0, r_chop, r_amp};
      default: w_rd_data = DEVICE_ID;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= WAIT_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      // Stay here until the pins are really visible and cs_n is high, so a
      // frame already in progress when reset was released is ignored whole.
      WAIT_IDLE: if (w_flushed && w_cs_s) w_state_next = IDLE;
      IDLE:      if (w_cs_fall)           w_state_next = CMD;
      CMD: begin
        if (w_cs_rise) begin
          w_state_next = IDLE;
        end else if (w_sclk_rise && (r_bit_cnt == 5'd7)) begin
          w_state_next = DATA;
        end
      end
      DATA:      if (w_cs_rise)           w_state_next = IDLE;
      default:                            w_state_next = WAIT_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: shifting, readback, commit and error pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_cmd        <= '0;
      r_rb         <= '0;
      r_bias       <= BIAS_RST;
      r_gain       <= '0;
      r_amp        <= 1'b0;
      r_chop       <= 1'b0;
      r_sdo        <= 1'b0;
      r_sdo_oe     <= 1'b0;
      r_cfg_update <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_cfg_update <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            r_bit_cnt <= '0;
          end
        end
        CMD, DATA: begin
          if (w_cs_rise) begin
            r_sdo    <= 1'b0;
            r_sdo_oe <= 1'b0;
            if (r_bit_cnt == 5'd16) begin
              // Only complete write frames touch the registers; the ID
              // address is read-only and produces no update pulse.
              if (!r_cmd[7]) begin
                case (r_cmd[1:0])
                  2'd0: r_bias <= r_shift;
                  2'd1: r_gain <= r_shift;
                  2'd2: begin
                    r_amp  <= r_shift[0];
                    r_chop <= r_shift[1];
                  end
                  default: ;
                endcase
                r_cfg_update <= (r_cmd[1:0] != 2'd3);
              end
            end else if (r_bit_cnt != 5'd0) begin
              r_frame_err <= 1'b1;
            end
          end else if (w_sclk_rise) begin
            r_shift <= w_cmd_next;
            if (r_bit_cnt != 5'd17) begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
            if ((r_state == CMD) && (r_bit_cnt == 5'd7)) begin
              r_cmd <= w_cmd_next;
              if (w_cmd_next[7]) begin
                // Present bit7 immediately so it is stable well before the
                // master samples the first data-phase edge.
                r_rb     <= w_rd_data;
                r_sdo    <= w_rd_data[7];
                r_sdo_oe <= 1'b1;
              end
            end else if ((r_state == DATA) && r_cmd[7]) begin
              // The master just sampled the current bit; move to the next.
              r_rb  <= {r_rb[6:0], 1'b0};
              r_sdo <= r_rb[6];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sdo_o        = r_sdo;
  assign sdo_oe_o     = r_sdo_oe;
  assign bias_code_o  = r_bias;
  assign gain_code_o  = r_gain;
  assign amp_en_o     = r_amp;
  assign chop_en_o    = r_chop;
  assign cfg_update_o = r_cfg_update;
  assign frame_err_o  = r_frame_err;

endmodule

// File: tb/tb_bias_trim_cfg.sv
// -----------------------------------------------------------------------------
// tb_bias_trim_cfg
//
// Bench for bias_trim_cfg. A serial master task drives frames; for each frame
// the expected outcome (update/error pulse counts, register state, readback
// byte) is derived from a small register model and pushed to a scoreboard
// queue, then popped and compared once the frame has completed.
// -----------------------------------------------------------------------------
module tb_bias_trim_cfg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk_i = 1'b0;
  logic       cs_n_i = 1'b1;
  logic       sdi_i = 1'b0;
  logic       sdo_o, sdo_oe_o;
  logic [7:0] bias_code_o, gain_code_o;
  logic       amp_en_o, chop_en_o, cfg_update_o, frame_err_o;
  bit         clk_en = 1'b0;

  bias_trim_cfg #(
    .SYNC_STAGES (2),
    .BIAS_RST    (8'h80),
    .DEVICE_ID   (8'hA5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sclk_i       (sclk_i),
    .cs_n_i       (cs_n_i),
    .sdi_i        (sdi_i),
    .sdo_o        (sdo_o),
    .sdo_oe_o     (sdo_oe_o),
    .bias_code_o  (bias_code_o),
    .gain_code_o  (gain_code_o),
    .amp_en_o     (amp_en_o),
    .chop_en_o    (chop_en_o),
    .cfg_update_o (cfg_update_o),
    .frame_err_o  (frame_err_o)
  );

  always #5 if (clk_en) clk = ~clk;

  typedef struct {
    logic       is_rd;
    logic [7:0] rd;
    int         upd;
    int         err;
    logic [7:0] bias;
    logic [7:0] gain;
    logic       amp;
    logic       chop;
  } exp_t;

  exp_t sb_q[$];

  logic [7:0] m_bias = 8'h80;
  logic [7:0] m_gain = 8'h00;
  logic       m_amp  = 1'b0;
  logic       m_chop = 1'b0;

  int n_chk   = 0;
  int n_fail  = 0;
  int upd_tot = 0;
  int err_tot = 0;
  int frame_no = 0;

  // Running pulse totals; frames compare before/after deltas.
  always @(negedge clk) begin
    if (cfg_update_o === 1'b1) upd_tot++;
    if (frame_err_o === 1'b1)  err_tot++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return m_bias;
      2'd1:    return m_gain;
      2'd2:    return {6'b0, m_chop, m_amp};
      default: return 8'hA5;
    endcase
  endfunction

  task automatic half_period();
    repeat (8) @(negedge clk);
  endtask

  // Drive one frame of nbits bits taken MSB-first from w (zeros beyond 16).
  // rst_at >= 0 pulses reset just before that bit, abandoning the frame.
  task automatic run_frame(input logic [15:0] w, input int nbits, input int rst_at);
    exp_t       ex, got;
    int         upd0, err0, oe_bad, changed;
    logic [7:0] rd;
    logic [7:0] b0, g0;
    logic       a0, c0, exp_oe;

    ex.is_rd = w[15] && (nbits == 16) && (rst_at < 0);
    ex.rd    = model_rd(w[9:8]);
    ex.upd   = 0;
    ex.err   = 0;
    if (rst_at >= 0) begin
      m_bias = 8'h80; m_gain = 8'h00; m_amp = 1'b0; m_chop = 1'b0;
    end else if (nbits == 16) begin
      if (!w[15] && (w[9:8] != 2'd3)) begin
        ex.upd = 1;
        case (w[9:8])
          2'd0:    m_bias = w[7:0];
          2'd1:    m_gain = w[7:0];
          default: begin m_amp = w[0]; m_chop = w[1]; end
        endcase
      end
    end else if (nbits != 0) begin
      ex.err = 1;
    end
    ex.bias = m_bias; ex.gain = m_gain; ex.amp = m_amp; ex.chop = m_chop;
    sb_q.push_back(ex);

    upd0 = upd_tot; err0 = err_tot; oe_bad = 0; changed = 0; rd = 8'h00;
    b0 = bias_code_o; g0 = gain_code_o; a0 = amp_en_o; c0 = chop_en_o;

    cs_n_i = 1'b0;
    half_period();
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk("midframe_rst_bias", 32'(bias_code_o), 32'h80);
        chk("midframe_rst_oe", 32'(sdo_oe_o), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
      sdi_i = (i < 16) ? w[15-i] : 1'b0;
      half_period();
      // Master view just before its sampling edge.
      if (rst_at < 0) begin
        exp_oe = (i >= 8) && w[15];
        if (sdo_oe_o !== exp_oe) oe_bad++;
        if (i >= 8 && i < 16) rd = {rd[6:0], sdo_o};
        if (bias_code_o !== b0 || gain_code_o !== g0 || amp_en_o !== a0 || chop_en_o !== c0)
          changed++;
      end
      sclk_i = 1'b1;
      half_period();
      sclk_i = 1'b0;
    end
    half_period();
    if (rst_at < 0) begin
      if (bias_code_o !== b0 || gain_code_o !== g0 || amp_en_o !== a0 || chop_en_o !== c0)
        changed++;
    end
    cs_n_i = 1'b1;
    repeat (12) @(negedge clk);

    got = sb_q.pop_front();
    chk("cfg_update_pulses", 32'(upd_tot - upd0), 32'(got.upd));
    chk("frame_err_pulses", 32'(err_tot - err0), 32'(got.err));
    chk("bias_code", 32'(bias_code_o), 32'(got.bias));
    chk("gain_code", 32'(gain_code_o), 32'(got.gain));
    chk("amp_en", 32'(amp_en_o), 32'(got.amp));
    chk("chop_en", 32'(chop_en_o), 32'(got.chop));
    chk("sdo_oe_after_frame", 32'(sdo_oe_o), 32'h0);
    chk("sdo_after_frame", 32'(sdo_o), 32'h0);
    if (rst_at < 0) begin
      chk("sdo_oe_phase_errors", 32'(oe_bad), 32'h0);
      chk("trim_changed_midframe", 32'(changed), 32'h0);
    end
    if (got.is_rd) chk("readback", 32'(rd), 32'(got.rd));
    $display("frame %0d: word=0x%04h bits=%0d rst_at=%0d rd=0x%02h bias=0x%02h gain=0x%02h amp=%0b chop=%0b",
             frame_no, w, nbits, rst_at, rd, bias_code_o, gain_code_o, amp_en_o, chop_en_o);
    frame_no++;
  endtask

  initial begin
    logic [1:0] ra;
    logic [7:0] rdat;

    // Reset with no clock running: outputs must reach reset values at once.
    #2 rst = 1'b1;
    #3;
    chk("reset_bias", 32'(bias_code_o), 32'h80);
    chk("reset_gain", 32'(gain_code_o), 32'h00);
    chk("reset_amp", 32'(amp_en_o), 32'h0);
    chk("reset_chop", 32'(chop_en_o), 32'h0);
    chk("reset_sdo_oe", 32'(sdo_oe_o), 32'h0);
    chk("reset_sdo", 32'(sdo_o), 32'h0);
    chk("reset_pulses", 32'({cfg_update_o, frame_err_o}), 32'h0);
    clk_en = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    run_frame(16'h003C, 16, -1);   // bias write
    run_frame(16'h0203, 16, -1);   // amp_en and chop_en
    run_frame(16'h015A, 16, -1);   // gain write
    run_frame(16'h8100, 16, -1);   // read gain -> 0x5A
    run_frame(16'h8300, 16, -1);   // read ID
    run_frame(16'h03FF, 16, -1);   // ID write ignored
    run_frame(16'h8300, 16, -1);   // ID still 0xA5
    run_frame(16'h0177, 12, -1);   // short frame
    run_frame(16'h0099, 17, -1);   // long frame
    run_frame(16'h8000, 16, -1);   // read bias
    run_frame(16'h8200, 16, -1);   // read ctrl
    run_frame(16'hFD00, 16, -1);   // read gain with junk in cmd[6:2]
    run_frame(16'h0000, 0,  -1);   // bare cs_n pulse
    run_frame(16'h0011, 16, 10);   // reset after 10 bits
    run_frame(16'h0077, 16, -1);   // normal write after reset
    run_frame(16'h8000, 16, -1);

    for (int k = 0; k < 5; k++) begin
      ra   = 2'($urandom_range(0, 3));
      rdat = 8'($urandom_range(0, 255));
      run_frame({6'b0, ra, rdat}, 16, -1);
      run_frame({1'b1, 5'($urandom_range(0, 31)), ra, 8'h00}, 16, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
